// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, times mult/div with a countdown counter.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu (ops 9-12) accumulating into {HI,LO}.
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] RD
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [3:0]         op_q;

  logic               accept;
  logic               long_op;
  logic [CNT_W-1:0]   load_cycles;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        hi_n;
  logic [31:0]        lo_n;

  assign accept = Start & ~Req & ~Busy;

  always_comb begin
    long_op     = 1'b0;
    load_cycles = CNT_W'(MULT_CYCLES);
    case (MDUOp)
      OP_MULT, OP_MULTU: long_op = 1'b1;
      OP_DIV, OP_DIVU: begin
        long_op     = 1'b1;
        load_cycles = CNT_W'(DIV_CYCLES);
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: long_op = 1'b1;
`endif
      default: long_op = 1'b0;
    endcase
  end

  // Sign-extending to 64 bits makes the low 64 bits of the product the signed result.
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    hi_n   = HI;
    lo_n   = LO;
    case (op_q)
      OP_MULT:  {hi_n, lo_n} = prod_s;
      OP_MULTU: {hi_n, lo_n} = prod_u;
      OP_DIV: begin
        if (b_q != 32'd0) begin
          if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
            lo_n = 32'h8000_0000;
            hi_n = 32'd0;
          end else begin
            lo_n = $signed(a_q) / $signed(b_q);
            hi_n = $signed(a_q) % $signed(b_q);
          end
        end
      end
      OP_DIVU: begin
        if (b_q != 32'd0) begin
          lo_n = a_q / b_q;
          hi_n = a_q % b_q;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {hi_n, lo_n} = {HI, LO} + prod_s;
      OP_MADDU: {hi_n, lo_n} = {HI, LO} + prod_u;
      OP_MSUB:  {hi_n, lo_n} = {HI, LO} - prod_s;
      OP_MSUBU: {hi_n, lo_n} = {HI, LO} - prod_u;
`endif
      default: begin
        hi_n = HI;
        lo_n = LO;
      end
    endcase
  end

  always_comb begin
    case (MDUOp)
      OP_MFHI: RD = HI;
      OP_MFLO: RD = LO;
      default: RD = 32'd0;
    endcase
  end

  // Req only gates acceptance; an operation already in RUN always completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      Busy  <= 1'b0;
      HI    <= 32'd0;
      LO    <= 32'd0;
      count <= '0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      op_q  <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (long_op) begin
              a_q   <= A;
              b_q   <= B;
              op_q  <= MDUOp;
              count <= load_cycles;
              state <= S_RUN;
              Busy  <= 1'b1;
            end else if (MDUOp == OP_MTHI) begin
              HI <= A;
            end else if (MDUOp == OP_MTLO) begin
              LO <= A;
            end
          end
        end
        S_RUN: begin
          if (count == CNT_W'(1)) begin
            HI    <= hi_n;
            LO    <= lo_n;
            count <= '0;
            state <= S_IDLE;
            Busy  <= 1'b0;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: vector table of long ops plus hand-written corner sequences.
// Build with MDU_MADD_EN defined to exercise the accumulate ops.
module tb_mdu_sequencer;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd11;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          cycles;
  } vec_t;

  vec_t vecs[9];

  mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (start),
    .MDUOp (mdu_op),
    .A     (a),
    .B     (b),
    .Req   (req),
    .Busy  (busy),
    .HI    (hi),
    .LO    (lo),
    .RD    (rd)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One-cycle Start pulse; returns #1 after the accepting edge.
  task automatic drive_start(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                             input logic rq);
    @(negedge clk);
    start  = 1'b1;
    mdu_op = op;
    a      = av;
    b      = bv;
    req    = rq;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mdu_op = OP_NONE;
    req    = 1'b0;
  endtask

  // Issue a long op, count Busy cycles, then compare {HI,LO} with the scoreboard entry.
  task automatic run_long(input string name, input logic [3:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input logic [63:0] exp, input int exp_cycles,
                          input bit inject);
    int cycles;
    logic [63:0] e;
    exp_q.push_back(exp);
    drive_start(op, av, bv, 1'b0);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      if (inject && cycles == 2) begin
        start = 1'b1; mdu_op = OP_DIV; a = 32'd100; b = 32'd7;
      end else if (inject && cycles == 3) begin
        mdu_op = OP_MTHI; a = 32'h0000_DEAD;
      end else if (inject && cycles == 4) begin
        start = 1'b0; mdu_op = OP_NONE;
      end
      @(posedge clk);
      #1;
    end
    start  = 1'b0;
    mdu_op = OP_NONE;
    check({name, " busy_cycles"}, 64'(cycles), 64'(exp_cycles));
    e = exp_q.pop_front();
    check({name, " hi_lo"}, {hi, lo}, e);
  endtask

  initial begin
    vecs[0] = '{"mult_neg",     OP_MULT,  32'hFFFF_FFFF, 32'd2,         64'hFFFF_FFFF_FFFF_FFFE, 5};
    vecs[1] = '{"multu_big",    OP_MULTU, 32'hFFFF_FFFF, 32'd2,         64'h0000_0001_FFFF_FFFE, 5};
    vecs[2] = '{"div_neg7_2",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 10};
    vecs[3] = '{"divu_100_7",   OP_DIVU,  32'd100,       32'd7,         64'h0000_0002_0000_000E, 10};
    vecs[4] = '{"div_overflow", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 10};
    vecs[5] = '{"mult_pos",     OP_MULT,  32'h1234_5678, 32'h10,        64'h0000_0001_2345_6780, 5};
    vecs[6] = '{"mult_minsq",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 5};
    vecs[7] = '{"multu_maxsq",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5};
    vecs[8] = '{"div_7_neg2",   OP_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 10};

    reset = 1'b1; start = 1'b0; mdu_op = OP_NONE; a = 32'd0; b = 32'd0; req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset rd", 64'(rd), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++)
      run_long(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].cycles, 1'b0);

    // mthi/mtlo and divide by zero
    drive_start(OP_MTHI, 32'h11, 32'd0, 1'b0);
    check("mthi hi", 64'(hi), 64'h11);
    check("mthi busy", 64'(busy), 64'd0);
    drive_start(OP_MTLO, 32'h22, 32'd0, 1'b0);
    check("mtlo lo", 64'(lo), 64'h22);
    run_long("divu_by_zero", OP_DIVU, 32'd7, 32'd0, 64'h0000_0011_0000_0022, 10, 1'b0);

    drive_start(OP_MTHI, 32'h1234, 32'd0, 1'b0);
    check("mthi2 hi", 64'(hi), 64'h1234);
    check("mthi2 busy", 64'(busy), 64'd0);
    check("mthi2 lo kept", 64'(lo), 64'h22);

    // Combinational reads
    @(negedge clk);
    mdu_op = OP_MFLO; #1;
    check("mflo rd", 64'(rd), 64'h22);
    mdu_op = OP_MFHI; #1;
    check("mfhi rd", 64'(rd), 64'h1234);
    mdu_op = OP_NONE; #1;
    check("none rd", 64'(rd), 64'd0);
    drive_start(OP_MFHI, 32'd0, 32'd0, 1'b0);
    check("mfhi start busy", 64'(busy), 64'd0);

    // Req cancels Start, including mtlo
    drive_start(OP_MULT, 32'd5, 32'd5, 1'b1);
    check("req mult busy", 64'(busy), 64'd0);
    drive_start(OP_MTLO, 32'h99, 32'd0, 1'b1);
    @(posedge clk); #1;
    check("req busy later", 64'(busy), 64'd0);
    check("req hi_lo", {hi, lo}, 64'h0000_1234_0000_0022);

    // Op 0 and undefined op
    drive_start(OP_NONE, 32'h55, 32'h66, 1'b0);
    drive_start(4'd13, 32'h55, 32'h66, 1'b0);
    check("undef busy", 64'(busy), 64'd0);
    check("undef hi_lo", {hi, lo}, 64'h0000_1234_0000_0022);

    // Start during RUN is ignored; the mult commits on schedule
    run_long("mult_busy_start", OP_MULT, 32'hFFFF_FFFF, 32'd3, 64'hFFFF_FFFF_FFFF_FFFD, 5, 1'b1);

    // Reset on the 3rd busy cycle of div discards the result
    drive_start(OP_DIV, 32'd100, 32'd3, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid reset busy", 64'(busy), 64'd0);
    check("mid reset hi_lo", {hi, lo}, 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check("post reset quiet", {31'd0, busy, hi, lo}, 64'd0);
    run_long("mult_after_reset", OP_MULT, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, 5, 1'b0);

    // Accumulate ops
    drive_start(OP_MTHI, 32'd0, 32'd0, 1'b0);
    drive_start(OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
`ifdef MDU_MADD_EN
    run_long("madd_carry", OP_MADD, 32'd1, 32'd1, 64'h0000_0001_0000_0000, 5, 1'b0);
    run_long("msub_borrow", OP_MSUB, 32'd1, 32'd1, 64'h0000_0000_FFFF_FFFF, 5, 1'b0);
`else
    drive_start(OP_MADD, 32'd1, 32'd1, 1'b0);
    check("madd off busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("madd off hi_lo", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multiply/divide unit controller for the E stage of the 5-stage MIPS pipeline.
- Accepts one MDU instruction per start pulse and sequences fixed-latency mult/div through a countdown counter.
- Owns the architectural HI/LO registers and serves mfhi/mflo reads.
- Drives the busy and start indications that the hazard unit uses to stall mult/div/mf/mt instructions in D.

Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu (and madd family when enabled); legal range ≥1.
- DIV_CYCLES, 10, busy duration of div/divu; legal range ≥1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  E-stage instruction is an MDU operation this cycle.
- MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu.
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- Req  input  1  interrupt/exception flush this cycle; cancels any Start.
- Busy  output  1  operation in progress (registered).
- HI  output  32  architectural HI.
- LO  output  32  architectural LO.
- RD  output  32  mfhi → HI, mflo → LO, else 0 (combinational on MDUOp).

Behaviour:
- Reset: Busy=0, HI=0, LO=0, counter=0, operand latches=0. Reset wins over every other input, including mid-operation; an in-flight result is discarded.
- Accept condition: Start & !Req & !Busy at a rising edge. Start while Busy is a protocol error; it is ignored and HI/LO are unaffected. Start with Req=1 is ignored entirely, including mthi/mtlo.
- mult/multu/div/divu on accept:
  - Latch A, B and op.
  - Load counter with MULT_CYCLES or DIV_CYCLES; Busy=1 from the next cycle.
- States:
  - IDLE (Busy=0).
  - RUN (Busy=1, counter decrements each edge).
  - On the edge where counter==1: commit HI/LO and go to IDLE.
  - Busy is high for exactly N cycles; new HI/LO are visible in the first cycle Busy is low.
- mult: signed 64-bit product, {HI,LO}=A*B. multu: unsigned product.
- div: LO=signed quotient truncated toward zero, HI=remainder with the sign of the dividend. divu: unsigned.
- Divide by zero: full DIV_CYCLES busy period, HI/LO left unchanged.
- Overflow corner div 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo on accept: HI or LO = A at that edge, Busy stays 0, no counter activity.
- mfhi/mflo: combinational read, no state change, never sets Busy.
- op 0 or an undefined op with Start: no effect.
- Req during RUN does not abort: an already-accepted operation completes, because it belongs to an instruction that has passed E.

Optional Feature:
- MDU_MADD_EN defined:
  - ops 9–12 are accepted like mult and take MULT_CYCLES.
  - On commit, {HI,LO} = {HI,LO} ± product. madd/msub use a signed product, maddu/msubu an unsigned one, with 64-bit modular wrap.
  - The accumulator value used is {HI,LO} at commit time.
- MDU_MADD_EN undefined: ops 9–12 are treated as op 0 (no Busy, no HI/LO change).

Test Plan:
- Start mult, A=0xFFFFFFFF, B=2 → Busy=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7), B=2 → Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 with prior HI=0x11, LO=0x22 → 10 busy cycles, HI/LO stay 0x11/0x22.
- mthi A=0x1234 → HI=0x1234 at the next edge with Busy=0; mflo → RD=LO in the same cycle.
- Start mult with Req=1 → Busy stays 0 and HI/LO unchanged; Start during RUN → ignored, the original result commits on schedule.
- reset asserted on the 3rd busy cycle of div → next cycle Busy=0, HI=LO=0; a new mult after reset completes normally in 5 cycles.
- With MDU_MADD_EN, HI=0, LO=0xFFFFFFFF, madd A=1, B=1 → HI=1, LO=0 after 5 cycles; without the macro, the same stimulus → Busy=0, HI/LO unchanged.
